wb_port_arbiter: RTL

- Owns the single write port of the 32x32 register bank and shares it between two requesters: the execute stage (EX) and the load-return path (LD).
- Loads returning from memory have priority. EX results that lose arbitration wait in a small in-order skid FIFO.
- A load scoreboard and a hazard output let decode stall on operands that are not yet written.
- Sits between EX/LSU and the register bank's writeRegister/rd/dataToWrite inputs.

---
 rtl/wb_pkg.sv | 20 ++
 rtl/wb_skid_fifo.sv | 85 ++++++++
 rtl/wb_port_arbiter.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared definitions for the register-bank write-back arbiter.
//   ADDR_W     : register index width (32 registers)
//   DATA_W     : register data width
//   NUM_REGS   : number of architectural registers (width of the scoreboard)
//   REG_ZERO   : index of the hard-wired zero register, never written
//   wb_entry_t : one pending write-back {rd, data}
package wb_pkg;

    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 1 << ADDR_W;

    localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_skid_fifo.sv
// In-order skid FIFO holding EX results that lost the write port to a load.
// Circular buffer of wb_entry_t; DEPTH must be a power of two (>= 2) so the
// pointers wrap naturally.
// Ports:
//   clock, reset_n          : clock, asynchronous active-low reset
//   push, push_entry        : append an entry at the tail
//   pop                     : drop the head entry
//   head_entry              : current head (valid when count != 0)
//   count                   : occupancy, 0..DEPTH
//   view_rd / view_valid    : entries in age order (index 0 = head/oldest)
//   view_data               : matching data view, only with WB_FORWARD_EN
// Configuration macro: WB_FORWARD_EN (adds the view_data port).
module wb_skid_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          push,
    input  wb_entry_t                     push_entry,
    input  logic                          pop,
    output wb_entry_t                     head_entry,
    output logic [CNT_W-1:0]              count,
`ifdef WB_FORWARD_EN
    output logic [DEPTH-1:0][DATA_W-1:0]  view_data,
`endif
    output logic [DEPTH-1:0][ADDR_W-1:0]  view_rd,
    output logic [DEPTH-1:0]              view_valid
);

    wb_entry_t        mem_q [DEPTH];
    wb_entry_t        mem_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        if (push) begin
            mem_d[tail_q] = push_entry;
            tail_d        = tail_q + PTR_W'(1);
        end
        if (pop) begin
            head_d = head_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage carries no reset: an empty count makes stale slots invisible.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    // Age-ordered view so callers can search oldest->youngest by index.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            view_rd[i]    = mem_q[head_q + PTR_W'(i)].rd;
`ifdef WB_FORWARD_EN
            view_data[i]  = mem_q[head_q + PTR_W'(i)].data;
`endif
            view_valid[i] = (CNT_W'(i) < count_q);
        end
    end

    assign head_entry = mem_q[head_q];
    assign count      = count_q;

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register bank's single write port between the EX stage and the
// load-return path. Loads win; losing EX results wait in an in-order skid
// FIFO. A load scoreboard plus in-flight compares drive the decode hazard.
// Ports:
//   clock, reset_n                 : clock, asynchronous active-low reset
//   ex_valid/ex_ready/ex_rd/ex_data : EX result handshake
//   ld_issue/ld_issue_rd           : load issued (sets scoreboard bit)
//   ld_valid/ld_rd/ld_data         : load return, never back-pressured
//   dec_rs1/dec_rs2/dec_rd         : decode indices checked for hazards
//   hazard                         : decode must stall
//   wr_en/wr_rd/wr_data            : registered bank write port
//   fifo_count, busy_mask          : observation of FIFO and scoreboard
//   fwd1_*/fwd2_*                  : operand forwarding (zero unless enabled)
// Configuration macro: WB_FORWARD_EN enables operand forwarding.
module wb_port_arbiter
    import wb_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               ex_valid,
    output logic               ex_ready,
    input  logic [ADDR_W-1:0]  ex_rd,
    input  logic [DATA_W-1:0]  ex_data,
    input  logic               ld_issue,
    input  logic [ADDR_W-1:0]  ld_issue_rd,
    input  logic               ld_valid,
    input  logic [ADDR_W-1:0]  ld_rd,
    input  logic [DATA_W-1:0]  ld_data,
    input  logic [ADDR_W-1:0]  dec_rs1,
    input  logic [ADDR_W-1:0]  dec_rs2,
    input  logic [ADDR_W-1:0]  dec_rd,
    output logic               hazard,
    output logic               wr_en,
    output logic [ADDR_W-1:0]  wr_rd,
    output logic [DATA_W-1:0]  wr_data,
    output logic [CNT_W-1:0]   fifo_count,
    output logic [NUM_REGS-1:0] busy_mask,
    output logic               fwd1_valid,
    output logic               fwd2_valid,
    output logic [DATA_W-1:0]  fwd1_data,
    output logic [DATA_W-1:0]  fwd2_data
);

    logic                          wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]             wr_rd_q, wr_rd_d;
    logic [DATA_W-1:0]             wr_data_q, wr_data_d;
    logic [NUM_REGS-1:0]           busy_q, busy_d;

    logic                          push, pop;
    wb_entry_t                     push_entry, head_entry;
    logic [CNT_W-1:0]              count;
    logic [FIFO_DEPTH-1:0][ADDR_W-1:0] view_rd;
    logic [FIFO_DEPTH-1:0]         view_valid;
`ifdef WB_FORWARD_EN
    logic [FIFO_DEPTH-1:0][DATA_W-1:0] view_data;
`endif

    logic ex_acc, ex_live, ld_live, fifo_ne;

    assign ex_ready = (count < CNT_W'(FIFO_DEPTH));
    assign ex_acc   = ex_valid && ex_ready;
    // rd==0 results are consumed but never reach the bank or the FIFO.
    assign ex_live  = ex_acc && (ex_rd != REG_ZERO);
    assign ld_live  = ld_valid && (ld_rd != REG_ZERO);
    assign fifo_ne  = (count != '0);

    assign push_entry = '{rd: ex_rd, data: ex_data};

    wb_skid_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clock      (clock),
        .reset_n    (reset_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head_entry (head_entry),
        .count      (count),
`ifdef WB_FORWARD_EN
        .view_data  (view_data),
`endif
        .view_rd    (view_rd),
        .view_valid (view_valid)
    );

    // Write selection: load, then FIFO head, then EX bypass (only when FIFO empty).
    always_comb begin
        wr_en_d   = 1'b0;
        wr_rd_d   = wr_rd_q;
        wr_data_d = wr_data_q;
        pop       = 1'b0;
        if (ld_live) begin
            wr_en_d   = 1'b1;
            wr_rd_d   = ld_rd;
            wr_data_d = ld_data;
        end else if (fifo_ne) begin
            pop       = 1'b1;
            wr_en_d   = 1'b1;
            wr_rd_d   = head_entry.rd;
            wr_data_d = head_entry.data;
        end else if (ex_live) begin
            wr_en_d   = 1'b1;
            wr_rd_d   = ex_rd;
            wr_data_d = ex_data;
        end
        push = ex_live && (ld_live || fifo_ne);
    end

    // Scoreboard: set applied after clear so a same-cycle issue wins.
    always_comb begin
        busy_d = busy_q;
        if (ld_live) begin
            busy_d[ld_rd] = 1'b0;
        end
        if (ld_issue && (ld_issue_rd != REG_ZERO)) begin
            busy_d[ld_issue_rd] = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_en_q   <= 1'b0;
            wr_rd_q   <= '0;
            wr_data_q <= '0;
            busy_q    <= '0;
        end else begin
            wr_en_q   <= wr_en_d;
            wr_rd_q   <= wr_rd_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
        end
    end

    // Register still has a pending write queued or on the port.
    function automatic logic in_flight(input logic [ADDR_W-1:0] r);
        logic hit;
        hit = wr_en_q && (wr_rd_q == r);
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (view_valid[i] && (view_rd[i] == r)) hit = 1'b1;
        end
        return hit;
    endfunction

    function automatic logic full_match(input logic [ADDR_W-1:0] r);
        return (r != REG_ZERO) && (busy_q[r] || in_flight(r));
    endfunction

`ifdef WB_FORWARD_EN
    // Scan oldest to youngest so the last hit is the youngest value.
    function automatic logic [DATA_W:0] fwd_lookup(input logic [ADDR_W-1:0] rs);
        logic [DATA_W:0] res;
        res = '0;
        if (rs != REG_ZERO) begin
            if (wr_en_q && (wr_rd_q == rs)) res = {1'b1, wr_data_q};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                if (view_valid[i] && (view_rd[i] == rs)) res = {1'b1, view_data[i]};
            end
            if (ex_live && (ex_rd == rs)) res = {1'b1, ex_data};
        end
        return res;
    endfunction

    logic [DATA_W:0] fwd1_res, fwd2_res;
    assign fwd1_res   = fwd_lookup(dec_rs1);
    assign fwd2_res   = fwd_lookup(dec_rs2);
    assign fwd1_valid = fwd1_res[DATA_W];
    assign fwd1_data  = fwd1_res[DATA_W-1:0];
    assign fwd2_valid = fwd2_res[DATA_W];
    assign fwd2_data  = fwd2_res[DATA_W-1:0];

    // Every in-flight source match is covered by forwarding; only loads still
    // outstanding in memory stall sources. dec_rd keeps the full check (WAW).
    assign hazard = ((dec_rs1 != REG_ZERO) && busy_q[dec_rs1])
                 || ((dec_rs2 != REG_ZERO) && busy_q[dec_rs2])
                 || full_match(dec_rd);
`else
    assign fwd1_valid = 1'b0;
    assign fwd2_valid = 1'b0;
    assign fwd1_data  = '0;
    assign fwd2_data  = '0;
    assign hazard     = full_match(dec_rs1) || full_match(dec_rs2) || full_match(dec_rd);
`endif

    assign wr_en      = wr_en_q;
    assign wr_rd      = wr_rd_q;
    assign wr_data    = wr_data_q;
    assign fifo_count = count;
    assign busy_mask  = busy_q;

endmodule
